// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key synchroniser, debouncer and press/release/long-press pulse generator
//
// Each key gets its own identical slice. The slice has a 2-flop synchroniser and a
// 4-state FSM that counts 1 ms ticks of stable level. It also has registered
// level and pulse outputs.
//
// Ports:
//   clk          system clock
//   rstN         synchronous active-low reset
//   iTick1ms     one-clk strobe, once per millisecond
//   iKeyN        raw asynchronous keys, 0 = pressed
//   oKeyLevel    debounced key state, 1 = pressed
//   oKeyPress    one-clk pulse per debounced press
//   oKeyRelease  one-clk pulse per debounced release
//   oKeyLong     one-clk pulse when a press has been held LONG_MS ticks
//
// Build option: define KEY_DEBOUNCE_LONG_PRESS_EN to include the long-press counters.
// Without it, oKeyLong is constant 0 and LONG_MS has no effect.
module key_debounce #(
   parameter int KEY_NUM     = 4,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               iTick1ms,
   input  logic [KEY_NUM-1:0] iKeyN,
   output logic [KEY_NUM-1:0] oKeyLevel,
   output logic [KEY_NUM-1:0] oKeyPress,
   output logic [KEY_NUM-1:0] oKeyRelease,
   output logic [KEY_NUM-1:0] oKeyLong
);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

   // A wait completes on the tick that lifts the count from DEBOUNCE_MS-1 to DEBOUNCE_MS.
   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_MS - 1);

   for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
      logic       sync_meta;
      logic       s;
      state_t     state;
      state_t     state_nxt;
      logic [7:0] deb_cnt;
      logic [7:0] deb_cnt_nxt;
      logic       deb_done;
      logic       level_nxt;
      logic       press_nxt;
      logic       release_nxt;
      logic       level_q;
      logic       press_q;
      logic       release_q;

      assign deb_done = iTick1ms && (deb_cnt == DEB_LAST);

      // State register, synchroniser and registered outputs.
      always_ff @(posedge clk) begin
         if (!rstN) begin
            sync_meta <= 1'b1;
            s         <= 1'b1;
            state     <= IDLE;
            deb_cnt   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync_meta <= iKeyN[k];
            s         <= sync_meta;
            state     <= state_nxt;
            deb_cnt   <= deb_cnt_nxt;
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
         end
      end

      // Next state. The level check comes before the tick check, so a bounce that
      // lands on the completing tick aborts the wait.
      always_comb begin
         state_nxt   = state;
         deb_cnt_nxt = deb_cnt;
         case (state)
            IDLE: begin
               if (!s) begin
                  state_nxt   = PRESS_WAIT;
                  deb_cnt_nxt = '0;
               end
            end
            PRESS_WAIT: begin
               if (s) begin
                  state_nxt = IDLE;
               end else if (iTick1ms) begin
                  deb_cnt_nxt = deb_cnt + 8'd1;
                  if (deb_done) state_nxt = PRESSED;
               end
            end
            PRESSED: begin
               if (s) begin
                  state_nxt   = RELEASE_WAIT;
                  deb_cnt_nxt = '0;
               end
            end
            RELEASE_WAIT: begin
               if (!s) begin
                  state_nxt = PRESSED;
               end else if (iTick1ms) begin
                  deb_cnt_nxt = deb_cnt + 8'd1;
                  if (deb_done) state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      // Output decode, registered above so that the pulses and the level move together.
      always_comb begin
         level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
         press_nxt   = (state == PRESS_WAIT) && !s && deb_done;
         release_nxt = (state == RELEASE_WAIT) && s && deb_done;
      end

      assign oKeyLevel[k]   = level_q;
      assign oKeyPress[k]   = press_q;
      assign oKeyRelease[k] = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
      localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);
      localparam logic [15:0] LONG_MAX  = 16'(LONG_MS);

      logic [15:0] long_cnt;
      logic        long_step;
      logic        long_q;

      // Counts only while held in PRESSED. It saturates, so the pulse fires once
      // per press. It is frozen (not cleared) across a release bounce.
      assign long_step = (state == PRESSED) && !s && iTick1ms && (long_cnt != LONG_MAX);

      always_ff @(posedge clk) begin
         if (!rstN) begin
            long_cnt <= '0;
            long_q   <= 1'b0;
         end else begin
            if (press_nxt) begin
               long_cnt <= '0;
            end else if (long_step) begin
               long_cnt <= long_cnt + 16'd1;
            end
            long_q <= long_step && (long_cnt == LONG_LAST);
         end
      end

      assign oKeyLong[k] = long_q;
`else
      // Constant 0 for every legal LONG_MS.
      assign oKeyLong[k] = (LONG_MS == 0);
`endif
   end

endmodule
